simon_sched: RTL and testbench
==============================

SIMON_SCHED -- requirements
Module: simon_sched

Interface
REQ-001 Parameter ROUNDS, default 72: number of Simon 128/256 rounds and round-key buffer depth.
REQ-002 Parameter WORD, default 64: word width in bits.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port res_n, input, 1: reset, synchronous, active-low.
REQ-005 Port key, input, 256: master key; k0=key[63:0], k1=key[127:64], k2=key[191:128], k3=key[255:192].
REQ-006 Port key_valid / key_ready, input / output, 1 each: key handshake; transfer on an edge with both high.
REQ-007 Port ks_start, output, 1: one-cycle start pulse to the key generator.
REQ-008 Port ks_valid, input, 1: generator presents a new round key on ks_word this cycle.
REQ-009 Port ks_word, input, 64: generated round key k4..k(ROUNDS-1), in order.
REQ-010 Port pt, input, 128: plaintext {x,y}, x=pt[127:64].
REQ-011 Port pt_valid / pt_ready, input / output, 1 each: plaintext handshake.
REQ-012 Port ct, output, 128: ciphertext {x,y}; held stable while ct_valid is high.
REQ-013 Port ct_valid / ct_ready, output / input, 1 each: ciphertext handshake.
REQ-014 Port keyed, output, 1: round-key buffer holds a complete valid schedule.
REQ-015 Port busy, output, 1: high in KEXP, ENC or OUT.

Function
REQ-016 States SHALL be IDLE, KEXP, KEYED, ENC, OUT.
REQ-017 key_ready SHALL be high only in IDLE and KEYED; pt_ready SHALL be high only in KEYED.
REQ-018 Key handshake SHALL write k0..k3 into buffer entries 0..3, clear keyed, pulse ks_start the next cycle, enter KEXP.
REQ-019 In KEXP, each cycle with ks_valid high SHALL write ks_word into the buffer at a 7-bit write index starting at 4 and increment the index.
REQ-020 The write that stores entry ROUNDS-1 SHALL set keyed and transition to KEYED on the same edge; ks_valid outside KEXP SHALL be ignored.
REQ-021 In KEYED, simultaneous key_valid and pt_valid SHALL accept the key only (rekey wins); pt_ready SHALL be low in that cycle.
REQ-022 pt handshake SHALL load x,y, clear the round counter, enter ENC.
REQ-023 In ENC, each cycle SHALL apply one round: x' = y XOR ((x<<<1) AND (x<<<8)) XOR (x<<<2) XOR k[r], y' = x, r = r+1.
REQ-024 After round ROUNDS-1 the block SHALL enter OUT with ct={x,y}, ct_valid high: ct_valid first high 73 edges after the pt handshake edge.
REQ-025 In OUT, ct_valid and ct SHALL hold until the ct_ready edge, then return to KEYED with ct_valid low on the same edge.
REQ-026 keyed SHALL remain high across ENC/OUT; schedule reused for any number of blocks.
REQ-027 key_valid and pt_valid during KEXP, ENC or OUT SHALL not be accepted and SHALL not alter state.

Reset
REQ-028 res_n low at an edge SHALL force IDLE, key_ready=0 that cycle then 1, pt_ready=0, ct_valid=0, ct=0, ks_start=0, keyed=0, busy=0, counters=0.
REQ-029 Reset mid-KEXP, ENC or OUT SHALL abandon the operation; a new key is required before encryption.
REQ-030 Buffer contents need not be cleared; keyed=0 marks them invalid.

Verification
REQ-031 Key 1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100, 68 ks_valid words from a reference generator, pt 74206e69206d6f6f_6d69732061207369 -> ct 8d2b5579afc8a3a0_3bf72a87efe7b868, ct_valid 73 edges after pt handshake.
REQ-032 ks_valid gapped (every other cycle) -> keyed rises only after the 68th word; result unchanged.
REQ-033 In KEYED, key_valid and pt_valid high together -> key accepted, ks_start pulses, pt_ready low until keyed rises again.
REQ-034 ct_ready held low 10 cycles in OUT -> ct stable, pt_ready low, then KEYED one edge after ct_ready.
REQ-035 res_n low for one edge at round 30 of ENC -> all outputs at reset values; pt_valid ignored until a new key completes.
REQ-036 Two back-to-back blocks under one key -> both ciphertexts correct, ks_start pulses only once.

Source files
------------

// File: rtl/simon_sched.sv
// simon_sched: Simon 128/256 round-key buffer and iterative block encryptor.
// The master key supplies k0..k3; an external generator streams k4..k(ROUNDS-1)
// over ks_valid/ks_word. Once the schedule is complete, blocks are encrypted
// one round per cycle and reuse the stored schedule until the next rekey.
//
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are high. A source holds valid and its payload until that edge; ready
// may depend combinationally on valid (pt_ready drops when key_valid is high
// in KEYED so that a rekey always wins over a plaintext).
module simon_sched #(
    parameter int ROUNDS = 72,
    parameter int WORD   = 64
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic [4*WORD-1:0]  key,
    input  logic               key_valid,
    output logic               key_ready,
    output logic               ks_start,
    input  logic               ks_valid,
    input  logic [WORD-1:0]    ks_word,
    input  logic [2*WORD-1:0]  pt,
    input  logic               pt_valid,
    output logic               pt_ready,
    output logic [2*WORD-1:0]  ct,
    output logic               ct_valid,
    input  logic               ct_ready,
    output logic               keyed,
    output logic               busy
);

    localparam int IW = 7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KEXP  = 3'd1,
        KEYED = 3'd2,
        ENC   = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   widx_q;
    logic [IW-1:0]   rcnt_q;
    logic [WORD-1:0] x_q, y_q;
    logic [WORD-1:0] rk [ROUNDS];

    logic            key_acc;
    logic            pt_acc;
    logic            ks_wr;
    logic            ks_last;
    logic            enc_step;
    logic            enc_done;
    logic [WORD-1:0] round_key;
    logic [WORD-1:0] x_rol1, x_rol2, x_rol8;
    logic [WORD-1:0] x_next;

    assign key_acc  = key_valid && key_ready;
    assign pt_acc   = pt_valid && pt_ready;
    assign ks_wr    = (state_q == KEXP) && ks_valid;
    assign ks_last  = ks_wr && (widx_q == IW'(ROUNDS - 1));
    assign enc_step = (state_q == ENC) && (rcnt_q != IW'(ROUNDS));
    assign enc_done = (state_q == ENC) && (rcnt_q == IW'(ROUNDS));

    // One Simon round on the current x/y with the key for round rcnt_q.
    always_comb begin
        round_key = rk[rcnt_q];
        x_rol1    = {x_q[WORD-2:0], x_q[WORD-1]};
        x_rol2    = {x_q[WORD-3:0], x_q[WORD-1:WORD-2]};
        x_rol8    = {x_q[WORD-9:0], x_q[WORD-1:WORD-8]};
        x_next    = y_q ^ (x_rol1 & x_rol8) ^ x_rol2 ^ round_key;
    end

    // Next-state and handshake outputs; ready signals are held low during reset.
    always_comb begin
        state_d   = state_q;
        key_ready = 1'b0;
        pt_ready  = 1'b0;
        ct_valid  = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                key_ready = res_n;
                if (key_valid && res_n) state_d = KEXP;
            end
            KEXP: begin
                busy = 1'b1;
                if (ks_last) state_d = KEYED;
            end
            KEYED: begin
                key_ready = res_n;
                pt_ready  = res_n && !key_valid;
                if (key_valid && res_n)     state_d = KEXP;
                else if (pt_valid && res_n) state_d = ENC;
            end
            ENC: begin
                busy = 1'b1;
                if (enc_done) state_d = OUT;
            end
            OUT: begin
                busy     = 1'b1;
                ct_valid = 1'b1;
                if (ct_ready) state_d = KEYED;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, counters, cipher state and status flags.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q  <= IDLE;
            widx_q   <= '0;
            rcnt_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            ct       <= '0;
            ks_start <= 1'b0;
            keyed    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ks_start <= key_acc;
            if (key_acc) begin
                keyed  <= 1'b0;
                widx_q <= IW'(4);
            end
            if (ks_wr) begin
                widx_q <= widx_q + 1'b1;
                if (ks_last) keyed <= 1'b1;
            end
            if (pt_acc) begin
                x_q    <= pt[2*WORD-1:WORD];
                y_q    <= pt[WORD-1:0];
                rcnt_q <= '0;
            end
            if (enc_step) begin
                x_q    <= x_next;
                y_q    <= x_q;
                rcnt_q <= rcnt_q + 1'b1;
            end
            if (enc_done) ct <= {x_q, y_q};
        end
    end

    // Round-key buffer; contents are only trusted while keyed is high.
    always_ff @(posedge clk) begin
        if (key_acc) begin
            for (int i = 0; i < 4; i++) rk[i] <= key[WORD*i +: WORD];
        end
        if (ks_wr) rk[widx_q] <= ks_word;
    end

endmodule

// File: tb/tb_simon_sched.sv
// tb_simon_sched: bench for simon_sched with a behavioural key-schedule
// generator, a cipher model and a ciphertext scoreboard.
module tb_simon_sched;

    localparam int ROUNDS = 72;
    localparam int WORD   = 64;

    logic         clk = 1'b0;
    logic         res_n;
    logic [255:0] key;
    logic         key_valid;
    logic         key_ready;
    logic         ks_start;
    logic         ks_valid;
    logic [63:0]  ks_word;
    logic [127:0] pt;
    logic         pt_valid;
    logic         pt_ready;
    logic [127:0] ct;
    logic         ct_valid;
    logic         ct_ready;
    logic         keyed;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int ks_start_cnt = 0;

    logic [127:0] exp_q[$];
    logic [63:0]  ks_m [ROUNDS];
    logic [61:0]  z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

    localparam logic [255:0] REF_KEY = 256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] REF_PT  = 128'h74206e69206d6f6f_6d69732061207369;
    localparam logic [127:0] REF_CT  = 128'h8d2b5579afc8a3a0_3bf72a87efe7b868;

    simon_sched #(.ROUNDS(ROUNDS), .WORD(WORD)) dut (
        .clk(clk), .res_n(res_n),
        .key(key), .key_valid(key_valid), .key_ready(key_ready),
        .ks_start(ks_start), .ks_valid(ks_valid), .ks_word(ks_word),
        .pt(pt), .pt_valid(pt_valid), .pt_ready(pt_ready),
        .ct(ct), .ct_valid(ct_valid), .ct_ready(ct_ready),
        .keyed(keyed), .busy(busy)
    );

    // clock / reset block
    always #5 clk = ~clk;

    always @(posedge clk) if (ks_start) ks_start_cnt++;

    // ---------------- model ----------------
    function automatic logic [63:0] rol(input logic [63:0] v, input int n);
        return (v << n) | (v >> (64 - n));
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    task automatic gen_ks(input logic [255:0] k);
        logic [63:0] tmp;
        for (int i = 0; i < 4; i++) ks_m[i] = k[64*i +: 64];
        for (int i = 4; i < ROUNDS; i++) begin
            tmp = ror(ks_m[i-1], 3) ^ ks_m[i-3];
            tmp = tmp ^ ror(tmp, 1);
            ks_m[i] = ~ks_m[i-4] ^ tmp ^ {63'd0, z4[61 - ((i - 4) % 62)]} ^ 64'd3;
        end
    endtask

    function automatic logic [127:0] model_enc(input logic [127:0] p);
        logic [63:0] x, y, t;
        x = p[127:64];
        y = p[63:0];
        for (int r = 0; r < ROUNDS; r++) begin
            t = x;
            x = y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ ks_m[r];
            y = t;
        end
        return {x, y};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key_hs(input logic [255:0] k);
        int n;
        gen_ks(k);
        key = k;
        key_valid = 1'b1;
        #1;
        n = 0;
        while (!key_ready && n < 300) begin
            tick();
            n++;
        end
        if (!key_ready) begin
            errors++;
            $display("FAIL key_hs_timeout key_ready=%0b required=1", key_ready);
        end
        checks++;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic feed_words(input int lo, input int hi, input bit gap);
        for (int i = lo; i <= hi; i++) begin
            ks_valid = 1'b1;
            ks_word  = ks_m[i];
            tick();
            ks_valid = 1'b0;
            ks_word  = $urandom();
            if (gap) tick();
        end
    endtask

    task automatic pt_hs(input logic [127:0] p);
        int n;
        pt = p;
        pt_valid = 1'b1;
        #1;
        n = 0;
        while (!pt_ready && n < 300) begin
            tick();
            n++;
        end
        if (!pt_ready) begin
            errors++;
            $display("FAIL pt_hs_timeout pt_ready=%0b required=1", pt_ready);
        end
        checks++;
        tick();
        pt_valid = 1'b0;
    endtask

    // Waits for ct_valid, checks latency and data against the scoreboard,
    // then holds ct_ready low for hold cycles before completing the transfer.
    task automatic collect(input int hold);
        int n;
        logic [127:0] e;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ct_valid && n < 300);
        checks++;
        if (n !== 73) begin
            errors++;
            $display("FAIL ct_latency got=%0d expected=73", n);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        checks++;
        if (ct !== e) begin
            errors++;
            $display("FAIL ct_data got=%h expected=%h", ct, e);
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++;
            if (ct !== e || ct_valid !== 1'b1 || pt_ready !== 1'b0) begin
                errors++;
                $display("FAIL ct_hold ct=%h ct_valid=%0b pt_ready=%0b expected ct=%h valid=1 ready=0",
                         ct, ct_valid, pt_ready, e);
            end
        end
        ct_ready = 1'b1;
        tick();
        ct_ready = 1'b0;
        checks++;
        if (ct_valid !== 1'b0 || busy !== 1'b0 || keyed !== 1'b1) begin
            errors++;
            $display("FAIL ct_release ct_valid=%0b busy=%0b keyed=%0b expected 0 0 1", ct_valid, busy, keyed);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        res_n = 1'b0;
        tick();
        tick();
        checks++;
        if (key_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_key_ready_low got=%0b expected=0", key_ready);
        end
        res_n = 1'b1;
        #1;
        checks++;
        if (key_ready !== 1'b1 || pt_ready !== 1'b0 || ct_valid !== 1'b0 || ct !== 128'd0 ||
            ks_start !== 1'b0 || keyed !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values kr=%0b pr=%0b cv=%0b ct=%h kss=%0b keyed=%0b busy=%0b expected 1 0 0 0 0 0 0",
                     key_ready, pt_ready, ct_valid, ct, ks_start, keyed, busy);
        end
    endtask

    task automatic test_known_vector();
        ks_start_cnt = 0;
        key_hs(REF_KEY);
        checks++;
        if (ks_start !== 1'b1 || keyed !== 1'b0 || busy !== 1'b1 || key_ready !== 1'b0) begin
            errors++;
            $display("FAIL kv_start kss=%0b keyed=%0b busy=%0b kr=%0b expected 1 0 1 0", ks_start, keyed, busy, key_ready);
        end
        feed_words(4, ROUNDS - 2, 1'b0);
        checks++;
        if (keyed !== 1'b0 || ks_start_cnt !== 1) begin
            errors++;
            $display("FAIL kv_before_last keyed=%0b starts=%0d expected keyed=0 starts=1", keyed, ks_start_cnt);
        end
        feed_words(ROUNDS - 1, ROUNDS - 1, 1'b0);
        checks++;
        if (keyed !== 1'b1 || busy !== 1'b0 || pt_ready !== 1'b1) begin
            errors++;
            $display("FAIL kv_keyed keyed=%0b busy=%0b pr=%0b expected 1 0 1", keyed, busy, pt_ready);
        end
        exp_q.push_back(REF_CT);
        pt_hs(REF_PT);
        checks++;
        if (busy !== 1'b1 || pt_ready !== 1'b0 || key_ready !== 1'b0 || keyed !== 1'b1) begin
            errors++;
            $display("FAIL kv_enc_flags busy=%0b pr=%0b kr=%0b keyed=%0b expected 1 0 0 1", busy, pt_ready, key_ready, keyed);
        end
        collect(0);
    endtask

    task automatic test_gapped();
        key_hs(REF_KEY);
        // a competing key during KEXP must not be taken
        key = ~REF_KEY;
        key_valid = 1'b1;
        #1;
        checks++;
        if (key_ready !== 1'b0) begin
            errors++;
            $display("FAIL gap_key_ready_kexp got=%0b expected=0", key_ready);
        end
        feed_words(4, ROUNDS - 2, 1'b1);
        key_valid = 1'b0;
        checks++;
        if (keyed !== 1'b0) begin
            errors++;
            $display("FAIL gap_keyed_early got=%0b expected=0", keyed);
        end
        feed_words(ROUNDS - 1, ROUNDS - 1, 1'b0);
        checks++;
        if (keyed !== 1'b1) begin
            errors++;
            $display("FAIL gap_keyed got=%0b expected=1", keyed);
        end
        exp_q.push_back(REF_CT);
        pt_hs(REF_PT);
        collect(0);
    endtask

    task automatic test_rekey_wins();
        logic [255:0] k2;
        logic [127:0] p;
        k2 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        p  = {$urandom(), $urandom(), $urandom(), $urandom()};
        ks_start_cnt = 0;
        key = k2;
        key_valid = 1'b1;
        pt = p;
        pt_valid = 1'b1;
        #1;
        checks++;
        if (pt_ready !== 1'b0 || key_ready !== 1'b1) begin
            errors++;
            $display("FAIL rekey_ready pr=%0b kr=%0b expected 0 1", pt_ready, key_ready);
        end
        gen_ks(k2);
        tick();
        key_valid = 1'b0;
        checks++;
        if (ks_start !== 1'b1 || keyed !== 1'b0 || busy !== 1'b1 || pt_ready !== 1'b0) begin
            errors++;
            $display("FAIL rekey_accept kss=%0b keyed=%0b busy=%0b pr=%0b expected 1 0 1 0", ks_start, keyed, busy, pt_ready);
        end
        feed_words(4, ROUNDS - 2, 1'b0);
        checks++;
        if (pt_ready !== 1'b0 || keyed !== 1'b0 || ks_start_cnt !== 1) begin
            errors++;
            $display("FAIL rekey_kexp pr=%0b keyed=%0b starts=%0d expected 0 0 1", pt_ready, keyed, ks_start_cnt);
        end
        feed_words(ROUNDS - 1, ROUNDS - 1, 1'b0);
        pt_valid = 1'b0;
        #1;
        checks++;
        if (keyed !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rekey_keyed keyed=%0b busy=%0b expected 1 0", keyed, busy);
        end
        exp_q.push_back(model_enc(p));
        pt_hs(p);
        collect(0);
    endtask

    task automatic test_backpressure();
        logic [127:0] p;
        p = {$urandom(), $urandom(), $urandom(), $urandom()};
        exp_q.push_back(model_enc(p));
        pt_hs(p);
        collect(10);
    endtask

    task automatic test_reset_mid_enc();
        pt_hs({$urandom(), $urandom(), $urandom(), $urandom()});
        for (int i = 0; i < 30; i++) tick();
        res_n = 1'b0;
        tick();
        res_n = 1'b1;
        #1;
        checks++;
        if (key_ready !== 1'b1 || pt_ready !== 1'b0 || ct_valid !== 1'b0 || ct !== 128'd0 ||
            ks_start !== 1'b0 || keyed !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_values kr=%0b pr=%0b cv=%0b ct=%h kss=%0b keyed=%0b busy=%0b expected 1 0 0 0 0 0 0",
                     key_ready, pt_ready, ct_valid, ct, ks_start, keyed, busy);
        end
        pt = REF_PT;
        pt_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (pt_ready !== 1'b0 || busy !== 1'b0 || ct_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_pt_ignored pr=%0b busy=%0b cv=%0b expected 0 0 0", pt_ready, busy, ct_valid);
            end
        end
        pt_valid = 1'b0;
        key_hs(REF_KEY);
        feed_words(4, ROUNDS - 1, 1'b0);
        exp_q.push_back(REF_CT);
        pt_hs(REF_PT);
        collect(0);
    endtask

    task automatic test_back_to_back();
        logic [255:0] k;
        logic [127:0] p;
        k = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        ks_start_cnt = 0;
        key_hs(k);
        feed_words(4, ROUNDS - 1, 1'b0);
        // stray generator words in KEYED must not touch the schedule
        for (int i = 0; i < 4; i++) begin
            ks_valid = 1'b1;
            ks_word  = $urandom();
            tick();
        end
        ks_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            p = {$urandom(), $urandom(), $urandom(), $urandom()};
            exp_q.push_back(model_enc(p));
            pt_hs(p);
            collect($urandom_range(0, 3));
        end
        checks++;
        if (ks_start_cnt !== 1 || keyed !== 1'b1) begin
            errors++;
            $display("FAIL b2b_single_start starts=%0d keyed=%0b expected 1 1", ks_start_cnt, keyed);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_empty left=%0d expected=0", exp_q.size());
        end
    endtask

    initial begin
        res_n     = 1'b0;
        key       = '0;
        key_valid = 1'b0;
        ks_valid  = 1'b0;
        ks_word   = '0;
        pt        = '0;
        pt_valid  = 1'b0;
        ct_ready  = 1'b0;
        test_reset();
        test_known_vector();
        test_gapped();
        test_rekey_wins();
        test_backpressure();
        test_reset_mid_enc();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
